mem_1r1w_fifo_ctrl: RTL
=======================

Name: mem_1r1w_fifo_ctrl

Overview:
Single-clock FIFO controller that drives one external 1R1W RAM macro: 2000 entries of 509 bits, registered read, active-low write and read enables.
- Write side: valid/ready stream in, converted into RAM writes.
- Read side: issues RAM reads ahead of demand and lands the returned words in a small output buffer, so the consumer sees a valid/ready stream at one word per cycle.
- Sits between packet producers and consumers wherever a deep RAM-backed buffer is instantiated.

Parameters:
DW, 509, data width
AW, 11, RAM address width
DEPTH, 2000, RAM entries; need not be a power of two
OBUF, 3, output buffer entries; must be at least 3 to cover the read loop latency

Ports:
clk  in  1  single clock; also drives the RAM wclk and rclk
rst  in  1  synchronous reset, active-high
s_valid  in  1  input word valid
s_ready  out  1  controller can accept a word
s_data  in  DW  input word
m_valid  out  1  output word valid
m_ready  in  1  consumer accepts the output word
m_data  out  DW  output word (head of the output buffer)
mem_waddr  out  AW  RAM write address
mem_wen  out  1  RAM write enable, active-low
mem_din  out  DW  RAM write data
mem_raddr  out  AW  RAM read address
mem_ren  out  1  RAM read enable, active-low
mem_dout  in  DW  RAM read data, valid the cycle after a read is issued
count  out  12  total words held: RAM + in flight + output buffer; maximum DEPTH+OBUF

Behaviour:
- Reset (rst high at a posedge):
  - wptr=0, rptr=0, mem_cnt=0, pending=0, buffer empty, count=0.
  - m_valid=0, mem_wen=1, mem_ren=1, s_ready=0 while rst is high.
  - RAM contents are not cleared.
  - Reset mid-operation discards in-flight reads and buffered words; a mem_dout returning in the cycle after reset is ignored.
- Write side:
  - s_ready = !rst && (mem_cnt < DEPTH).
  - On s_valid && s_ready: mem_wen=0, mem_waddr=wptr, mem_din=s_data, all combinational in that cycle.
  - wptr advances DEPTH-1 -> 0, otherwise +1.
  - With no accepted input, mem_wen=1.
- Read issue:
  - A read is issued in cycle N when mem_cnt > 0 && (buf_cnt + pending) < OBUF.
  - Issuing drives mem_ren=0 and mem_raddr=rptr; rptr wraps DEPTH-1 -> 0.
  - Otherwise mem_ren=1; mem_raddr is held, don't-care.
  - mem_cnt counts only words written in earlier cycles. A same-cycle write never makes mem_cnt nonzero, so the read and write addresses are never equal with both enables low.
  - mem_cnt next = mem_cnt + write - read.
- Read return:
  - mem_dout from the cycle-N read is valid in cycle N+1 and is pushed into the output buffer at the end of N+1.
  - pending (0..2) increments on issue and decrements on capture.
- Output:
  - m_valid = buf_cnt > 0; m_data = buffer head.
  - The head pops on m_valid && m_ready.
  - Push and pop in the same cycle are both honoured.
- Latency and throughput:
  - First-word latency: a word accepted in cycle T into an empty FIFO is read in T+1, captured at the end of T+2, and m_valid is high in T+3.
  - Sustained throughput is 1 word/cycle with s_valid and m_ready held high.
- Full and empty:
  - Full: mem_cnt == DEPTH gives s_ready=0. The output buffer still drains, which frees RAM entries via reads.
  - Empty: mem_cnt == 0 means no read is issued; m_valid falls after the last buffered word pops.
- count = mem_cnt + pending + buf_cnt, updated each cycle. It never exceeds DEPTH+OBUF.
- Backpressure: with m_ready low, at most OBUF reads are outstanding or buffered; no word is dropped or duplicated.

Test Plan:
- Reset, then one write of 0x1A5 (zero-extended) at cycle T -> mem_wen=0 with mem_waddr=0 in T; mem_ren=0 with mem_raddr=0 in T+1; m_valid=1 with m_data=0x1A5 in T+3; count=1 from T+1 until the pop.
- m_ready=0, write 2003 incrementing words -> s_ready falls after word 2003; count=2003; mem_ren never low while buf_cnt+pending=3. Then m_ready=1 -> words 0..2002 emerge in order.
- Streaming 5000 words with s_valid=m_ready=1 -> one word out per cycle after the 3-cycle fill; pointers wrap 1999->0 twice; no mem_waddr==mem_raddr collision with both enables low.
- Random s_valid/m_ready (50%) over 20000 words -> output order matches a scoreboard; count matches the model every cycle.
- rst asserted for one cycle while 500 words are held and 2 reads are pending -> next cycle count=0, m_valid=0, mem_wen=mem_ren=1. A following write of 0x3 emerges first, with no stale data.
- Single word written while the FIFO is empty and m_ready=1 throughout -> exactly one m_valid pulse, then count=0 and mem_ren stays 1.

Source files
------------

// File: rtl/mem_1r1w_fifo_ctrl.sv
// Single-clock FIFO controller for an external 1R1W RAM with registered read and active-low enables.
// It issues RAM reads ahead of demand into a small output buffer so the consumer can take one word per cycle.
module mem_1r1w_fifo_ctrl #(
  parameter int DW    = 509,
  parameter int AW    = 11,
  parameter int DEPTH = 2000,
  parameter int OBUF  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_din,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_ren,
  input  logic [DW-1:0] mem_dout,
  output logic [11:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(OBUF);
  localparam int NW = $clog2(OBUF + 1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_mem_cnt;
  logic [1:0]    r_pend;
  logic          r_rd_vld;
  logic [NW-1:0] r_buf_cnt;
  logic [BW-1:0] r_head;
  logic [BW-1:0] r_tail;
  logic [DW-1:0] r_buf [OBUF];
  logic [11:0]   r_count;

  logic          w_wr;
  logic          w_rd;
  logic          w_push;
  logic          w_pop;
  logic [NW:0]   w_occ;

  function automatic logic [AW-1:0] ram_ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  function automatic logic [BW-1:0] buf_ptr_inc(input logic [BW-1:0] p);
    if (p == BW'(OBUF - 1)) begin
      return {BW{1'b0}};
    end else begin
      return p + BW'(1);
    end
  endfunction

  // mem_cnt only reflects earlier-cycle writes, so a read never targets the slot being written.
  assign s_ready   = !rst && (r_mem_cnt < CW'(DEPTH));
  assign w_wr      = s_valid && s_ready;
  assign w_occ     = {1'b0, r_buf_cnt} + (NW+1)'(r_pend);
  assign w_rd      = !rst && (r_mem_cnt != {CW{1'b0}}) && (w_occ < (NW+1)'(OBUF));
  assign w_push    = r_rd_vld;
  assign m_valid   = !rst && (r_buf_cnt != {NW{1'b0}});
  assign w_pop     = m_valid && m_ready;
  assign m_data    = r_buf[r_head];

  assign mem_wen   = !w_wr;
  assign mem_waddr = r_wptr;
  assign mem_din   = s_data;
  assign mem_ren   = !w_rd;
  assign mem_raddr = r_rptr;
  assign count     = r_count;

  // Pointers, occupancy counters and the read-return tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= {AW{1'b0}};
      r_rptr    <= {AW{1'b0}};
      r_mem_cnt <= {CW{1'b0}};
      r_pend    <= 2'd0;
      r_rd_vld  <= 1'b0;
      r_buf_cnt <= {NW{1'b0}};
      r_head    <= {BW{1'b0}};
      r_tail    <= {BW{1'b0}};
      r_count   <= 12'd0;
    end else begin
      if (w_wr) begin
        r_wptr <= ram_ptr_inc(r_wptr);
      end
      if (w_rd) begin
        r_rptr <= ram_ptr_inc(r_rptr);
      end
      if (w_push) begin
        r_tail <= buf_ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= buf_ptr_inc(r_head);
      end
      r_mem_cnt <= r_mem_cnt + CW'(w_wr) - CW'(w_rd);
      r_pend    <= r_pend + 2'(w_rd) - 2'(w_push);
      r_rd_vld  <= w_rd;
      r_buf_cnt <= r_buf_cnt + NW'(w_push) - NW'(w_pop);
      r_count   <= r_count + 12'(w_wr) - 12'(w_pop);
    end
  end

  // Output buffer storage; the issue rule guarantees a free slot for every returning word.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_buf[r_tail] <= mem_dout;
    end
  end

endmodule
